// File: rtl/uart_tx_buffered_if.sv
// Enqueue handshake, break request and line/status bundle for uart_tx_buffered.
// master = word producer, slave = transmitter; widths follow DATA_BITS and FIFO_DEPTH.
interface uart_tx_buffered_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS-1:0]        i_Data;
  logic                        i_Valid;
  logic                        i_Break;
  logic                        o_Data;
  logic                        o_Ready;
  logic                        o_Idle;
  logic [$clog2(FIFO_DEPTH):0] o_Count;

  modport master (
    output i_Data, i_Valid, i_Break,
    input  o_Data, o_Ready, o_Idle, o_Count
  );

  modport slave (
    input  i_Data, i_Valid, i_Break,
    output o_Data, o_Ready, o_Idle, o_Count
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed framer, first start bit two edges after accept, frames back-to-back.
// o_Ready low while the FIFO is full (writes dropped); define UART_TX_BREAK_EN to add line-break support.

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdat_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  // A write against a full FIFO is refused even if a pop frees a slot on the same edge.
  assign full_o  = (count_q == FULL_CNT);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (count_q != '0);
  assign rdat_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module uart_tx_buffered #(
  parameter int         CLOCK_FREQ_Mhz = 12,
  parameter int         BAUD_RATE      = 9600,
  parameter int         DATA_BITS      = 8,
  parameter logic [1:0] PARITY_MODE    = 2'b00,
  parameter int         STOP_BITS      = 1,
  parameter int         FIFO_DEPTH     = 16
) (
  input logic               i_Clock,
  input logic               i_Reset,
  uart_tx_buffered_if.slave bus
);
  localparam int CLOCKS_PER_BIT = CLOCK_FREQ_Mhz * 1_000_000 / BAUD_RATE;
  localparam int CNT_W          = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int IDX_W          = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (PARITY_MODE == 2'b11) begin : g_bad_parity
    $error("uart_tx_buffered: PARITY_MODE 2'b11 is illegal");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_buffered: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_buffered: STOP_BITS must be 1..2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two in 2..256");
  end
  if (CLOCKS_PER_BIT < 1) begin : g_bad_baud
    $error("uart_tx_buffered: BAUD_RATE too high for CLOCK_FREQ_Mhz");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    ,
    BREAK,
    GAP
`endif
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0]       sh_q, sh_d;
  logic                       par_q, par_d;
  logic                       line_q, line_d;
  logic                       avail_q;

  logic                       bit_done;
  logic                       launch;
  logic                       pop;
  logic [DATA_BITS-1:0]       fifo_rdat;
  logic                       fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .push_i  (bus.i_Valid),
    .wdat_i  (bus.i_Data),
    .pop_i   (pop),
    .rdat_o  (fifo_rdat),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign bit_done = (cnt_q == CNT_LAST);

`ifndef UART_TX_BREAK_EN
  logic unused_break;
  assign unused_break = bus.i_Break;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_done ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    launch  = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef UART_TX_BREAK_EN
        if (bus.i_Break) state_d = BREAK;
        else
`endif
        if (avail_q) launch = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != 2'b00) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
`ifdef UART_TX_BREAK_EN
            if (bus.i_Break) state_d = BREAK;
            else
`endif
            if (avail_q) launch = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        cnt_d = '0;
        if (!bus.i_Break) state_d = GAP;
      end
      // Line held high for one full bit time after a break before any start bit.
      GAP: begin
        if (bit_done) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d = START;
      pop     = 1'b1;
      cnt_d   = '0;
      sh_d    = fifo_rdat;
      par_d   = (^fifo_rdat) ^ PARITY_MODE[0];
    end

    // The line register follows the next state so o_Data changes on the same edge as the FSM.
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = sh_d[0];
      PARITY:  line_d = par_d;
`ifdef UART_TX_BREAK_EN
      BREAK:   line_d = 1'b0;
`endif
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      line_q  <= line_d;
      // Occupancy seen by the FSM lags the FIFO by one edge, so a fresh word launches at accept+2.
      avail_q <= (fifo_count != '0);
    end
  end

  assign bus.o_Data  = line_q;
  assign bus.o_Ready = !fifo_full;
  assign bus.o_Idle  = (fifo_count == '0) && (state_q == IDLE);
  assign bus.o_Count = fifo_count;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: four configurations against a frame-level reference model.
module tb_uart_tx_buffered;
  localparam int CPB = 12;

  logic i_Clock = 1'b0;
  logic i_Reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [15:0] expv [4];
  int          elen [4];

  always #5 i_Clock = ~i_Clock;

  uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
  uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();
  uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc ();
  uart_tx_buffered_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifd ();

  uart_tx_buffered #(.CLOCK_FREQ_Mhz(12), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                     .PARITY_MODE(2'b00), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(ifa));
  uart_tx_buffered #(.CLOCK_FREQ_Mhz(12), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                     .PARITY_MODE(2'b01), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_b (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(ifb));
  uart_tx_buffered #(.CLOCK_FREQ_Mhz(12), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                     .PARITY_MODE(2'b10), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_c (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(ifc));
  uart_tx_buffered #(.CLOCK_FREQ_Mhz(12), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                     .PARITY_MODE(2'b00), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_d (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(ifd));

  // Reference frame: start 0, data LSB first, optional parity, then stop 1s (unwritten positions stay 1).
  function automatic logic [15:0] frame_vec(input int db, input int pm, input logic [8:0] d);
    logic [15:0] v;
    int          p;
    int          ones;
    v    = '1;
    v[0] = 1'b0;
    p    = 1;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      v[p] = d[i];
      if (d[i]) ones++;
      p++;
    end
    if (pm == 1) v[p] = (ones % 2 == 0);
    if (pm == 2) v[p] = (ones % 2 == 1);
    return v;
  endfunction

  task automatic set_exp(input int d, input int db, input int pm, input int sb, input logic [8:0] w);
    expv[d] = frame_vec(db, pm, w);
    elen[d] = 1 + db + ((pm != 0) ? 1 : 0) + sb;
  endtask

  function automatic logic line(input int d);
    case (d)
      0:       return ifa.o_Data;
      1:       return ifb.o_Data;
      2:       return ifc.o_Data;
      default: return ifd.o_Data;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
    cyc++;
  endtask

  task automatic push_a(input logic [7:0] w);
    ifa.i_Data  = w;
    ifa.i_Valid = 1'b1;
    tick();
    ifa.i_Valid = 1'b0;
  endtask

  // Compares every cycle of the selected lines against their expected frames; shorter frames then idle high.
  task automatic check_frames(input logic [3:0] mask, input string tag);
    int maxc;
    maxc = 0;
    for (int d = 0; d < 4; d++)
      if (mask[d] && elen[d] * CPB > maxc) maxc = elen[d] * CPB;
    for (int k = 0; k < maxc; k++) begin
      for (int d = 0; d < 4; d++) begin
        if (mask[d]) begin
          logic e;
          e = (k < elen[d] * CPB) ? expv[d][k / CPB] : 1'b1;
          chk($sformatf("%s.dut%0d.c%0d", tag, d, k), 32'(line(d)), 32'(e));
        end
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    logic [7:0] fillw [4];
    int         s_cyc;
    int         hi;

    ifa.i_Data = '0; ifa.i_Valid = 1'b0; ifa.i_Break = 1'b0;
    ifb.i_Data = '0; ifb.i_Valid = 1'b0; ifb.i_Break = 1'b0;
    ifc.i_Data = '0; ifc.i_Valid = 1'b0; ifc.i_Break = 1'b0;
    ifd.i_Data = '0; ifd.i_Valid = 1'b0; ifd.i_Break = 1'b0;
    i_Reset = 1'b1;
    repeat (3) tick();
    chk("rst_line",  32'(ifa.o_Data),  32'd1);
    chk("rst_ready", 32'(ifa.o_Ready), 32'd1);
    chk("rst_idle",  32'(ifa.o_Idle),  32'd1);
    chk("rst_count", 32'(ifa.o_Count), 32'd0);
    chk("rst_count_d", 32'(ifd.o_Count), 32'd0);
    i_Reset = 1'b0;
    tick();

    // 8'hA5 on 8N1: start bit two edges after accept, 120-cycle frame
    set_exp(0, 8, 0, 1, 9'h0A5);
    push_a(8'hA5);
    chk("acc_count", 32'(ifa.o_Count), 32'd1);
    chk("acc_idle",  32'(ifa.o_Idle),  32'd0);
    chk("acc_line",  32'(ifa.o_Data),  32'd1);
    tick();
    chk("acc1_line", 32'(ifa.o_Data), 32'd1);
    tick();
    chk("pop_count", 32'(ifa.o_Count), 32'd0);
    check_frames(4'b0001, "a5");
    chk("a5_idle",  32'(ifa.o_Idle),  32'd1);
    chk("a5_count", 32'(ifa.o_Count), 32'd0);

    for (int r = 0; r < 3; r++) begin
      w = 8'($urandom);
      repeat ($urandom_range(0, 4)) tick();
      set_exp(0, 8, 0, 1, {1'b0, w});
      push_a(w);
      chk($sformatf("rnd%0d_acc_line", r), 32'(ifa.o_Data), 32'd1);
      tick();
      tick();
      check_frames(4'b0001, $sformatf("rnd%0d", r));
    end

`ifndef UART_TX_BREAK_EN
    ifa.i_Break = 1'b1;
    set_exp(0, 8, 0, 1, 9'h03C);
    push_a(8'h3C);
    tick();
    tick();
    check_frames(4'b0001, "brk_ignored");
    ifa.i_Break = 1'b0;
`endif

    // FIFO fill while a frame is in flight, then a write refused on the pop edge
    push_a(8'h11);
    tick();
    tick();
    s_cyc = cyc;
    chk("fill_start", 32'(ifa.o_Data), 32'd0);
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      if (i < 4) fillw[i] = w;
      ifa.i_Data  = w;
      ifa.i_Valid = 1'b1;
      tick();
      if (i == 3) begin
        chk("fill4_count", 32'(ifa.o_Count), 32'd4);
        chk("fill4_ready", 32'(ifa.o_Ready), 32'd0);
      end
    end
    ifa.i_Valid = 1'b0;
    chk("fill_drop_count", 32'(ifa.o_Count), 32'd4);
    while (cyc < s_cyc + 119) tick();
    ifa.i_Data  = 8'hEE;
    ifa.i_Valid = 1'b1;
    tick();
    ifa.i_Valid = 1'b0;
    chk("pop_drop_count", 32'(ifa.o_Count), 32'd3);
    for (int i = 0; i < 4; i++) begin
      set_exp(0, 8, 0, 1, {1'b0, fillw[i]});
      check_frames(4'b0001, $sformatf("fill%0d", i));
    end
    chk("fill_idle",  32'(ifa.o_Idle),  32'd1);
    chk("fill_count", 32'(ifa.o_Count), 32'd0);

    // Reset 30 cycles into a frame with two words queued
    push_a(8'h00);
    tick();
    tick();
    s_cyc = cyc;
    push_a(8'h5A);
    push_a(8'h66);
    while (cyc < s_cyc + 30) tick();
    chk("pre_rst_line",  32'(ifa.o_Data),  32'd0);
    chk("pre_rst_count", 32'(ifa.o_Count), 32'd2);
    i_Reset = 1'b1;
    #1;
    chk("mid_rst_line",  32'(ifa.o_Data),  32'd1);
    chk("mid_rst_count", 32'(ifa.o_Count), 32'd0);
    chk("mid_rst_ready", 32'(ifa.o_Ready), 32'd1);
    chk("mid_rst_idle",  32'(ifa.o_Idle),  32'd1);
    repeat (2) tick();
    i_Reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      chk($sformatf("post_rst_quiet%0d", k), 32'(ifa.o_Data), 32'd1);
    end
    chk("post_rst_idle", 32'(ifa.o_Idle), 32'd1);
    set_exp(0, 8, 0, 1, 9'h0C3);
    push_a(8'hC3);
    chk("post_rst_acc_line", 32'(ifa.o_Data), 32'd1);
    tick();
    chk("post_rst_acc1_line", 32'(ifa.o_Data), 32'd1);
    tick();
    check_frames(4'b0001, "post_rst");

    // Parity and stop-bit variants in parallel: 8O1, 8E2, 7N2
    for (int r = 0; r < 3; r++) begin
      logic [7:0] wb, wc;
      logic [6:0] wd;
      wb = (r == 0) ? 8'h03 : 8'($urandom);
      wc = (r == 0) ? 8'h03 : 8'($urandom);
      wd = (r == 0) ? 7'h41 : 7'($urandom);
      set_exp(1, 8, 1, 1, {1'b0, wb});
      set_exp(2, 8, 2, 2, {1'b0, wc});
      set_exp(3, 7, 0, 2, {2'b0, wd});
      ifb.i_Data = wb; ifc.i_Data = wc; ifd.i_Data = wd;
      ifb.i_Valid = 1'b1; ifc.i_Valid = 1'b1; ifd.i_Valid = 1'b1;
      tick();
      ifb.i_Valid = 1'b0; ifc.i_Valid = 1'b0; ifd.i_Valid = 1'b0;
      tick();
      tick();
      check_frames(4'b1110, $sformatf("var%0d", r));
      chk($sformatf("var%0d_idle_b", r), 32'(ifb.o_Idle), 32'd1);
      chk($sformatf("var%0d_idle_c", r), 32'(ifc.o_Idle), 32'd1);
      chk($sformatf("var%0d_idle_d", r), 32'(ifd.o_Idle), 32'd1);
    end

`ifdef UART_TX_BREAK_EN
    // Break held 50 cycles with a word queued behind it
    ifa.i_Break = 1'b1;
    set_exp(0, 8, 0, 1, 9'h096);
    push_a(8'h96);
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("brk_low%0d", k), 32'(ifa.o_Data), 32'd0);
      if (k < 49) tick();
    end
    chk("brk_count", 32'(ifa.o_Count), 32'd1);
    ifa.i_Break = 1'b0;
    tick();
    hi = 0;
    while (ifa.o_Data === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    chk("brk_gap_ge_bit", 32'(hi >= CPB), 32'd1);
    chk("brk_gap_bounded", 32'(hi < 40), 32'd1);
    check_frames(4'b0001, "brk_frame");
`else
    hi = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
